// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_arbiter_pkg : shared FSM state encoding and default widths       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rom_arbiter_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_select : picks one requester, returns one-hot grant and index.    |
// | ROM_ARBITER_RR_EN: cyclic search from ptr; else lowest index wins.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_select
  import rom_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifdef ROM_ARBITER_RR_EN
  input  logic [ID_W-1:0]  ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             hit
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef ROM_ARBITER_RR_EN
      pos = (int'(ptr) + k) % N_REQ;
`else
      pos = k;
`endif
      if (!hit && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = ID_W'(pos);
        hit        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_arbiter : shares one asynchronous ROM among N_REQ requesters.    |
// | ROM_ARBITER_RR_EN selects round-robin; default is fixed priority.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(N_REQ)-1:0]  rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_data,
  output logic                        busy
);

  localparam int ID_W = id_width(N_REQ);

  state_t           state;
  state_t           state_nx;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  win_idx;
  logic             any_req;
  logic             accept;

`ifdef ROM_ARBITER_RR_EN
  logic [ID_W-1:0]  ptr;
`endif

  rr_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_select (
    .req   (req_valid),
`ifdef ROM_ARBITER_RR_EN
    .ptr   (ptr),
`endif
    .grant (grant),
    .idx   (win_idx),
    .hit   (any_req)
  );

  assign accept    = (state == IDLE) && any_req;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address and owner are latched once at acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        rom_addr <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        rsp_id   <= win_idx;
      end
      if (state == ISSUE) rsp_data <= rom_data;
    end
  end

`ifdef ROM_ARBITER_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_arbiter : directed scoreboard bench for rom_arbiter.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  logic [DW-1:0] rom [16];
  logic [10:0]   sb [$];
  logic [10:0]   exp_e;
  logic [AW-1:0] exp_addr;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ptr_m    = 0;
  int            w;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int j;
`ifdef ROM_ARBITER_RR_EN
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j]) return j;
    end
`else
    for (int k = 0; k < N; k++) begin
      j = k + 0 * p;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic sb_pop(input string tag);
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s empty: observed 0 entries expected 1", tag);
    end
    if (sb.size() > 0) begin
      exp_e = sb.pop_front();
      check({tag, " rsp_id"},   32'(rsp_id),   32'(exp_e[10:9]));
      check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_e[8:0]));
    end
  endtask

  // Entered in IDLE just after an edge; leaves in RESP just after the edge.
  task automatic access(input string tag, input bit scramble);
    #1;
    w = pick(req_valid, ptr_m);
    check({tag, " grant"}, 32'(req_ready), 32'(1) << w);
    exp_addr = req_addr[w*AW +: AW];
    sb.push_back({2'(w), rom[exp_addr]});
    ptr_m = (w + 1) % N;
    @(posedge clk); #1;
    if (scramble) req_addr = '1;
    check({tag, " issue busy"},      32'(busy),      32'd1);
    check({tag, " issue rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " issue rom_addr"},  32'(rom_addr),  32'(exp_addr));
    check({tag, " issue rsp_id"},    32'(rsp_id),    32'(w));
    check({tag, " issue req_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, " resp rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " resp rom_addr"},  32'(rom_addr),  32'(exp_addr));
    if (rsp_ready) sb_pop(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rom_addr"},  32'(rom_addr),  32'd0);
    check({tag, " rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, " rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = DW'(a * 29 + 7);
    rom[5]    = 9'h1A3;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle busy", 32'(busy), 32'd0);

    // All requesters valid for five grants: RR order 0,1,2,3,0 or always 0
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(3 * i + 2);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      access("all_valid", 1'b0);
      @(posedge clk); #1;
      check("all_valid back_idle", 32'(busy), 32'd0);
    end

    // Single request from requester 1 at address 5; inputs scrambled after accept
    req_valid = 4'b0010;
    req_addr  = '0;
    req_addr[1*AW +: AW] = 4'h5;
    access("single", 1'b1);
    @(posedge clk); #1;
    check("single back_idle", 32'(busy), 32'd0);

    // Stall in RESP for 10 cycles with requests pending
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(3 * i + 2);
    req_valid = '1;
    rsp_ready = 1'b0;
    access("stall", 1'b0);
    for (int c = 0; c < 10; c++) begin
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall rsp_data",  32'(rsp_data),  32'(sb[0][8:0]));
      check("stall rsp_id",    32'(rsp_id),    32'(sb[0][10:9]));
      check("stall rom_addr",  32'(rom_addr),  32'(exp_addr));
      check("stall req_ready", 32'(req_ready), 32'd0);
      check("stall busy",      32'(busy),      32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    sb_pop("stall");
    @(posedge clk); #1;
    check("stall release busy", 32'(busy), 32'd0);

    // Reset pulsed in the middle of ISSUE
    #1;
    w = pick(req_valid, ptr_m);
    check("abort grant", 32'(req_ready), 32'(1) << w);
    @(posedge clk); #1;
    check("abort issue busy", 32'(busy), 32'd1);
    #2;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_reset busy",      32'(busy),      32'd0);
    end
    check("post_reset sb_empty", 32'(sb.size()), 32'd0);

    // Service resumes with the pointer back at 0
    req_valid = '1;
    access("after_reset", 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b1001;
    access("pair", 1'b0);
    @(posedge clk); #1;
    check("final busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
